// File: rtl/bus_demux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bus_demux
//  Purpose  : Routes master requests to one slave port (or an internal error
//             responder) and returns responses in order, one target at a time.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_demux #(
  parameter int PORT_COUNT      = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             m_req_valid_i,
  output logic                             m_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]            m_addr_i,
  input  logic                             m_we_i,
  input  logic [DATA_WIDTH-1:0]            m_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]          m_be_i,
  output logic                             m_rsp_valid_o,
  input  logic                             m_rsp_ready_i,
  output logic [DATA_WIDTH-1:0]            m_rsp_rdata_o,
  output logic                             m_rsp_err_o,
  output logic [ADDR_WIDTH-1:0]            dec_addr_o,
  input  logic [$clog2(PORT_COUNT)-1:0]    dec_sel_i,
  input  logic                             dec_illegal_i,
  output logic [PORT_COUNT-1:0]            s_req_valid_o,
  input  logic [PORT_COUNT-1:0]            s_req_ready_i,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic                             s_we_o,
  output logic [DATA_WIDTH-1:0]            s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          s_be_o,
  input  logic [PORT_COUNT-1:0]            s_rsp_valid_i,
  output logic [PORT_COUNT-1:0]            s_rsp_ready_o,
  input  logic [PORT_COUNT*DATA_WIDTH-1:0] s_rsp_rdata_i,
  input  logic [PORT_COUNT-1:0]            s_rsp_err_i
);

  localparam int SEL_W = $clog2(PORT_COUNT);
  localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(MAX_OUTSTANDING);
  localparam logic [SEL_W:0]     c_port_lim = (SEL_W + 1)'(PORT_COUNT);

  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_tgt_err;
  logic [SEL_W-1:0]      r_tgt_sel;

  logic                  w_tgt_err;
  logic                  w_same_tgt;
  logic                  w_allow;
  logic                  w_slv_ready;
  logic                  w_req_fire;
  logic                  w_rsp_fire;
  logic [PORT_COUNT-1:0] w_sel_onehot;

  assign dec_addr_o = m_addr_i;
  assign s_addr_o   = m_addr_i;
  assign s_we_o     = m_we_i;
  assign s_wdata_o  = m_wdata_i;
  assign s_be_o     = m_be_i;

  // An out-of-range select is routed to the error responder like an illegal address.
  assign w_tgt_err  = dec_illegal_i | ({1'b0, dec_sel_i} >= c_port_lim);
  assign w_same_tgt = w_tgt_err ? r_tgt_err : (~r_tgt_err & (dec_sel_i == r_tgt_sel));
  assign w_allow    = rst_ni & ((r_cnt == '0) | w_same_tgt) & (r_cnt < c_cnt_max);

  genvar gi;
  generate
    for (gi = 0; gi < PORT_COUNT; gi++) begin : g_port
      assign w_sel_onehot[gi]  = ~w_tgt_err & (dec_sel_i == SEL_W'(gi));
      assign s_req_valid_o[gi] = m_req_valid_i & w_allow & w_sel_onehot[gi];
    end
  endgenerate

  assign w_slv_ready   = |(s_req_ready_i & w_sel_onehot);
  assign m_req_ready_o = w_allow & (w_tgt_err | w_slv_ready);
  assign w_req_fire    = m_req_valid_i & m_req_ready_o;
  assign w_rsp_fire    = m_rsp_valid_o & m_rsp_ready_i;

  always_comb begin
    m_rsp_valid_o = 1'b0;
    m_rsp_rdata_o = '0;
    m_rsp_err_o   = 1'b0;
    s_rsp_ready_o = '0;
    if (r_cnt != '0) begin
      if (r_tgt_err) begin
        m_rsp_valid_o = 1'b1;
        m_rsp_err_o   = 1'b1;
      end else begin
        for (int i = 0; i < PORT_COUNT; i++) begin
          if (r_tgt_sel == SEL_W'(i)) begin
            m_rsp_valid_o    = s_rsp_valid_i[i];
            m_rsp_rdata_o    = s_rsp_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            m_rsp_err_o      = s_rsp_err_i[i];
            s_rsp_ready_o[i] = m_rsp_ready_i;
          end
        end
      end
    end
  end

  // Target is only ever rewritten with an equal value while requests are outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_tgt_err <= 1'b0;
      r_tgt_sel <= '0;
    end else begin
      if (w_req_fire) begin
        r_tgt_err <= w_tgt_err;
        r_tgt_sel <= dec_sel_i;
      end
      if (w_req_fire && !w_rsp_fire) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end else if (!w_req_fire && w_rsp_fire) begin
        r_cnt <= r_cnt - c_cnt_w'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_demux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bus_demux
//  Purpose  : Directed scenarios plus randomized traffic against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_demux;
  localparam int PC = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          m_req_valid_i, m_req_ready_o;
  logic [AW-1:0] m_addr_i;
  logic          m_we_i;
  logic [DW-1:0] m_wdata_i;
  logic [DW/8-1:0] m_be_i;
  logic          m_rsp_valid_o, m_rsp_ready_i;
  logic [DW-1:0] m_rsp_rdata_o;
  logic          m_rsp_err_o;
  logic [AW-1:0] dec_addr_o;
  logic          dec_sel_i, dec_illegal_i;
  logic [PC-1:0] s_req_valid_o, s_req_ready_i;
  logic [AW-1:0] s_addr_o;
  logic          s_we_o;
  logic [DW-1:0] s_wdata_o;
  logic [DW/8-1:0] s_be_o;
  logic [PC-1:0] s_rsp_valid_i, s_rsp_ready_o;
  logic [PC*DW-1:0] s_rsp_rdata_i;
  logic [PC-1:0] s_rsp_err_i;

  int checks = 0;
  int failures = 0;
  int q[$];  // targets of outstanding requests, -1 = error responder

  always #5 clk_i = ~clk_i;

  bus_demux #(.PORT_COUNT(PC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_valid_i(m_req_valid_i), .m_req_ready_o(m_req_ready_o),
    .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_wdata_i(m_wdata_i), .m_be_i(m_be_i),
    .m_rsp_valid_o(m_rsp_valid_o), .m_rsp_ready_i(m_rsp_ready_i),
    .m_rsp_rdata_o(m_rsp_rdata_o), .m_rsp_err_o(m_rsp_err_o),
    .dec_addr_o(dec_addr_o), .dec_sel_i(dec_sel_i), .dec_illegal_i(dec_illegal_i),
    .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i),
    .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_wdata_o(s_wdata_o), .s_be_o(s_be_o),
    .s_rsp_valid_i(s_rsp_valid_i), .s_rsp_ready_o(s_rsp_ready_o),
    .s_rsp_rdata_i(s_rsp_rdata_i), .s_rsp_err_i(s_rsp_err_i)
  );

  // Address map of the stand-in decoder: 0x0xxx_xxxx port 0, 0x1xxx_xxxx port 1, else illegal.
  task automatic set_req(input bit v, input logic [31:0] a, input bit we);
    m_req_valid_i = v;
    m_addr_i      = a;
    m_we_i        = we;
    m_wdata_i     = $urandom;
    m_be_i        = 4'hF;
    case (a[31:28])
      4'h0:    begin dec_sel_i = 1'b0; dec_illegal_i = 1'b0; end
      4'h1:    begin dec_sel_i = 1'b1; dec_illegal_i = 1'b0; end
      default: begin dec_sel_i = a[0]; dec_illegal_i = 1'b1; end
    endcase
  endtask

  function automatic int cur_tgt();
    if (dec_illegal_i || int'(dec_sel_i) >= PC) return -1;
    return int'(dec_sel_i);
  endfunction

  function automatic bit exp_allow();
    int t = cur_tgt();
    return (q.size() == 0 || q[0] == t) && q.size() < MO;
  endfunction

  function automatic bit exp_req_ready();
    int t = cur_tgt();
    return exp_allow() && (t < 0 || s_req_ready_i[t] == 1'b1);
  endfunction

  function automatic bit exp_rsp_valid();
    if (q.size() == 0) return 1'b0;
    if (q[0] < 0) return 1'b1;
    return s_rsp_valid_i[q[0]];
  endfunction

  // Advance one clock, updating the model from the handshakes it predicts.
  task automatic tick();
    bit acc, hs;
    int t;
    t   = cur_tgt();
    acc = m_req_valid_i && exp_req_ready();
    hs  = m_rsp_ready_i && exp_rsp_valid();
    @(posedge clk_i);
    if (hs) void'(q.pop_front());
    if (acc) q.push_back(t);
    @(negedge clk_i);
  endtask

  task automatic drain();
    set_req(1'b0, 32'h0, 1'b0);
    s_rsp_valid_i = '1;
    m_rsp_ready_i = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      #1;
      tick();
    end
    s_rsp_valid_i = '0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    set_req(1'b1, 32'h1000_0000, 1'b0);
    s_req_ready_i = 2'b11; s_rsp_valid_i = 2'b11; m_rsp_ready_i = 1'b1;
    s_rsp_rdata_i = '0; s_rsp_err_i = '0;
    #1;
    checks++; if (m_req_ready_o !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", m_req_ready_o); end
    checks++; if (s_req_valid_o !== 2'b00) begin failures++; $display("FAIL reset_s_req_valid got=%b exp=00", s_req_valid_o); end
    checks++; if (m_rsp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", m_rsp_valid_o); end
    checks++; if (s_rsp_ready_o !== 2'b00) begin failures++; $display("FAIL reset_s_rsp_ready got=%b exp=00", s_rsp_ready_o); end
    checks++; if (dec_addr_o !== 32'h1000_0000) begin failures++; $display("FAIL dec_addr got=%h exp=10000000", dec_addr_o); end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    set_req(1'b0, 32'h0, 1'b0);
    s_rsp_valid_i = '0;
    q.delete();
  endtask

  task automatic test_single_read();
    s_req_ready_i = 2'b11; s_rsp_valid_i = '0; m_rsp_ready_i = 1'b1;
    set_req(1'b1, 32'h1000_0040, 1'b0);
    #1;
    checks++; if (s_req_valid_o !== 2'b10) begin failures++; $display("FAIL rd_s_req_valid got=%b exp=10", s_req_valid_o); end
    checks++; if (m_req_ready_o !== 1'b1) begin failures++; $display("FAIL rd_req_ready got=%b exp=1", m_req_ready_o); end
    checks++; if (s_addr_o !== 32'h1000_0040) begin failures++; $display("FAIL rd_s_addr got=%h exp=10000040", s_addr_o); end
    tick();
    set_req(1'b0, 32'h1000_0040, 1'b0);
    repeat (3) begin
      #1;
      checks++; if (m_rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rd_wait_rsp got=%b exp=0", m_rsp_valid_o); end
      tick();
    end
    s_rsp_valid_i = 2'b10; s_rsp_rdata_i = {32'hA5A5_0001, 32'hDEAD_BEEF}; s_rsp_err_i = 2'b01;
    #1;
    checks++; if (m_rsp_valid_o !== 1'b1) begin failures++; $display("FAIL rd_rsp_valid got=%b exp=1", m_rsp_valid_o); end
    checks++; if (m_rsp_rdata_o !== 32'hA5A5_0001) begin failures++; $display("FAIL rd_rdata got=%h exp=a5a50001", m_rsp_rdata_o); end
    checks++; if (m_rsp_err_o !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", m_rsp_err_o); end
    checks++; if (s_rsp_ready_o !== 2'b10) begin failures++; $display("FAIL rd_s_rsp_ready got=%b exp=10", s_rsp_ready_o); end
    tick();
    s_rsp_valid_i = '0; s_rsp_err_i = '0;
    #1;
    checks++; if (m_rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rd_after_rsp got=%b exp=0", m_rsp_valid_o); end
  endtask

  task automatic test_illegal();
    s_req_ready_i = 2'b11; s_rsp_valid_i = '0; m_rsp_ready_i = 1'b1;
    set_req(1'b1, 32'h2000_0000, 1'b0);
    #1;
    checks++; if (s_req_valid_o !== 2'b00) begin failures++; $display("FAIL ill_s_req_valid got=%b exp=00", s_req_valid_o); end
    checks++; if (m_req_ready_o !== 1'b1) begin failures++; $display("FAIL ill_req_ready got=%b exp=1", m_req_ready_o); end
    checks++; if (m_rsp_valid_o !== 1'b0) begin failures++; $display("FAIL ill_rsp_early got=%b exp=0", m_rsp_valid_o); end
    tick();
    set_req(1'b0, 32'h2000_0000, 1'b0);
    s_rsp_valid_i = 2'b11; s_rsp_rdata_i = {32'h1234_5678, 32'h9ABC_DEF0};
    #1;
    checks++; if (m_rsp_valid_o !== 1'b1) begin failures++; $display("FAIL ill_rsp_valid got=%b exp=1", m_rsp_valid_o); end
    checks++; if (m_rsp_rdata_o !== 32'h0) begin failures++; $display("FAIL ill_rdata got=%h exp=0", m_rsp_rdata_o); end
    checks++; if (m_rsp_err_o !== 1'b1) begin failures++; $display("FAIL ill_err got=%b exp=1", m_rsp_err_o); end
    checks++; if (s_rsp_ready_o !== 2'b00) begin failures++; $display("FAIL ill_s_rsp_ready got=%b exp=00", s_rsp_ready_o); end
    tick();
    s_rsp_valid_i = '0;
    #1;
    checks++; if (m_rsp_valid_o !== 1'b0) begin failures++; $display("FAIL ill_after_rsp got=%b exp=0", m_rsp_valid_o); end
  endtask

  task automatic test_max_outstanding();
    s_req_ready_i = 2'b11; s_rsp_valid_i = '0; m_rsp_ready_i = 1'b1;
    for (int k = 0; k < MO; k++) begin
      set_req(1'b1, 32'h0000_0100 + 32'(k * 4), 1'b1);
      #1;
      checks++; if (m_req_ready_o !== 1'b1) begin failures++; $display("FAIL max_accept[%0d] got=%b exp=1", k, m_req_ready_o); end
      tick();
    end
    set_req(1'b1, 32'h0000_0200, 1'b1);
    repeat (2) begin
      #1;
      checks++; if (m_req_ready_o !== 1'b0) begin failures++; $display("FAIL max_full_ready got=%b exp=0", m_req_ready_o); end
      checks++; if (s_req_valid_o !== 2'b00) begin failures++; $display("FAIL max_full_valid got=%b exp=00", s_req_valid_o); end
      tick();
    end
    s_rsp_valid_i = 2'b01; s_rsp_rdata_i = {32'h0, 32'h0000_00AA};
    #1;
    checks++; if (m_req_ready_o !== 1'b0) begin failures++; $display("FAIL max_hs_cycle_ready got=%b exp=0", m_req_ready_o); end
    checks++; if (m_rsp_valid_o !== 1'b1) begin failures++; $display("FAIL max_rsp_valid got=%b exp=1", m_rsp_valid_o); end
    tick();
    s_rsp_valid_i = '0;
    #1;
    checks++; if (m_req_ready_o !== 1'b1) begin failures++; $display("FAIL max_freed_ready got=%b exp=1", m_req_ready_o); end
    tick();
    drain();
    s_rsp_valid_i = 2'b11;
    #1;
    checks++; if (m_rsp_valid_o !== 1'b0) begin failures++; $display("FAIL max_drained got=%b exp=0", m_rsp_valid_o); end
    s_rsp_valid_i = '0;
  endtask

  task automatic test_switch_order();
    s_req_ready_i = 2'b11; s_rsp_valid_i = '0; m_rsp_ready_i = 1'b1;
    repeat (2) begin
      set_req(1'b1, 32'h0000_0010, 1'b0);
      #1;
      tick();
    end
    set_req(1'b1, 32'h1000_0010, 1'b0);
    #1;
    checks++; if (s_req_valid_o !== 2'b00) begin failures++; $display("FAIL sw_blocked_valid got=%b exp=00", s_req_valid_o); end
    checks++; if (m_req_ready_o !== 1'b0) begin failures++; $display("FAIL sw_blocked_ready got=%b exp=0", m_req_ready_o); end
    for (int k = 0; k < 2; k++) begin
      s_rsp_valid_i = 2'b11; s_rsp_rdata_i = {32'h3333_3333, 32'h1111_0000 + 32'(k)};
      #1;
      checks++; if (m_rsp_rdata_o !== 32'h1111_0000 + 32'(k)) begin failures++; $display("FAIL sw_order[%0d] got=%h exp=%h", k, m_rsp_rdata_o, 32'h1111_0000 + 32'(k)); end
      checks++; if (s_req_valid_o !== 2'b00) begin failures++; $display("FAIL sw_still_blocked[%0d] got=%b exp=00", k, s_req_valid_o); end
      checks++; if (s_rsp_ready_o !== 2'b01) begin failures++; $display("FAIL sw_s_rsp_ready[%0d] got=%b exp=01", k, s_rsp_ready_o); end
      tick();
    end
    s_rsp_valid_i = '0;
    #1;
    checks++; if (s_req_valid_o !== 2'b10) begin failures++; $display("FAIL sw_switched_valid got=%b exp=10", s_req_valid_o); end
    checks++; if (m_rsp_valid_o !== 1'b0) begin failures++; $display("FAIL sw_idle_rsp got=%b exp=0", m_rsp_valid_o); end
    tick();
    set_req(1'b0, 32'h0, 1'b0);
    s_rsp_valid_i = 2'b11; s_rsp_rdata_i = {32'h2222_0002, 32'h1111_FFFF};
    #1;
    checks++; if (m_rsp_rdata_o !== 32'h2222_0002) begin failures++; $display("FAIL sw_port1_rdata got=%h exp=22220002", m_rsp_rdata_o); end
    checks++; if (s_rsp_ready_o !== 2'b10) begin failures++; $display("FAIL sw_port1_ready got=%b exp=10", s_rsp_ready_o); end
    tick();
    s_rsp_valid_i = '0;
  endtask

  task automatic test_back_to_back();
    int n;
    s_req_ready_i = 2'b11; s_rsp_valid_i = '0; m_rsp_ready_i = 1'b1;
    repeat (2) begin
      set_req(1'b1, 32'h0000_0020, 1'b1);
      #1;
      tick();
    end
    set_req(1'b0, 32'h0000_0020, 1'b0);
    s_rsp_valid_i = 2'b01; m_rsp_ready_i = 1'b0;
    #1;
    checks++; if (m_rsp_valid_o !== 1'b1) begin failures++; $display("FAIL bp_rsp_valid got=%b exp=1", m_rsp_valid_o); end
    checks++; if (s_rsp_ready_o !== 2'b00) begin failures++; $display("FAIL bp_s_rsp_ready got=%b exp=00", s_rsp_ready_o); end
    tick();
    set_req(1'b1, 32'h0000_0024, 1'b1);
    m_rsp_ready_i = 1'b1;
    #1;
    checks++; if (m_req_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_req_ready got=%b exp=1", m_req_ready_o); end
    checks++; if (s_rsp_ready_o !== 2'b01) begin failures++; $display("FAIL b2b_s_rsp_ready got=%b exp=01", s_rsp_ready_o); end
    tick();
    set_req(1'b0, 32'h0, 1'b0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (!m_rsp_valid_o) break;
      tick();
      n++;
    end
    checks++; if (n != 2) begin failures++; $display("FAIL b2b_remaining got=%0d exp=2", n); end
    s_rsp_valid_i = '0;
    q.delete();
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    s_req_ready_i = 2'b11; s_rsp_valid_i = '0; m_rsp_ready_i = 1'b1;
    repeat (3) begin
      set_req(1'b1, 32'h0000_0030, 1'b0);
      #1;
      tick();
    end
    s_rsp_valid_i = 2'b01;
    #3;
    rst_ni = 1'b0;
    q.delete();
    #1;
    checks++; if (m_rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_rsp_valid got=%b exp=0", m_rsp_valid_o); end
    checks++; if (s_rsp_ready_o !== 2'b00) begin failures++; $display("FAIL rstmid_s_rsp_ready got=%b exp=00", s_rsp_ready_o); end
    checks++; if (m_req_ready_o !== 1'b0) begin failures++; $display("FAIL rstmid_req_ready got=%b exp=0", m_req_ready_o); end
    checks++; if (s_req_valid_o !== 2'b00) begin failures++; $display("FAIL rstmid_s_req_valid got=%b exp=00", s_req_valid_o); end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    set_req(1'b1, 32'h1000_0000, 1'b0);
    #1;
    checks++; if (m_rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_no_rsp got=%b exp=0", m_rsp_valid_o); end
    checks++; if (s_req_valid_o !== 2'b10) begin failures++; $display("FAIL rstmid_new_valid got=%b exp=10", s_req_valid_o); end
    tick();
    s_rsp_valid_i = '0;
    for (int k = 1; k <= MO; k++) begin
      #1;
      checks++; if (m_req_ready_o !== (k < MO)) begin failures++; $display("FAIL rstmid_cnt[%0d] got=%b exp=%b", k, m_req_ready_o, k < MO); end
      tick();
    end
    drain();
  endtask

  task automatic test_random();
    int t, sel;
    logic [PC-1:0] exp_srv, exp_srr;
    logic [DW-1:0] exp_rd;
    bit exp_rdy, exp_mv, exp_err;
    for (int it = 0; it < 400; it++) begin
      sel = $urandom_range(0, 5);
      set_req(1'($urandom), (sel < 3) ? {4'h0, 28'($urandom)} : (sel < 5) ? {4'h1, 28'($urandom)} : {4'h7, 28'($urandom)}, 1'($urandom));
      s_req_ready_i = PC'($urandom);
      s_rsp_valid_i = PC'($urandom);
      s_rsp_rdata_i = {$urandom, $urandom};
      s_rsp_err_i   = PC'($urandom);
      m_rsp_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      t       = cur_tgt();
      exp_srv = (m_req_valid_i && exp_allow() && t >= 0) ? PC'(1 << t) : '0;
      exp_rdy = exp_req_ready();
      exp_mv  = exp_rsp_valid();
      exp_srr = (q.size() > 0 && q[0] >= 0 && m_rsp_ready_i) ? PC'(1 << q[0]) : '0;
      checks++; if (s_req_valid_o !== exp_srv) begin failures++; $display("FAIL rnd_s_req_valid it=%0d got=%b exp=%b", it, s_req_valid_o, exp_srv); end
      checks++; if (m_req_ready_o !== exp_rdy) begin failures++; $display("FAIL rnd_req_ready it=%0d got=%b exp=%b", it, m_req_ready_o, exp_rdy); end
      checks++; if (m_rsp_valid_o !== exp_mv) begin failures++; $display("FAIL rnd_rsp_valid it=%0d got=%b exp=%b", it, m_rsp_valid_o, exp_mv); end
      checks++; if (s_rsp_ready_o !== exp_srr) begin failures++; $display("FAIL rnd_s_rsp_ready it=%0d got=%b exp=%b", it, s_rsp_ready_o, exp_srr); end
      if (exp_mv) begin
        exp_rd  = (q[0] < 0) ? '0 : s_rsp_rdata_i[q[0]*DW +: DW];
        exp_err = (q[0] < 0) ? 1'b1 : s_rsp_err_i[q[0]];
        checks++; if (m_rsp_rdata_o !== exp_rd) begin failures++; $display("FAIL rnd_rdata it=%0d got=%h exp=%h", it, m_rsp_rdata_o, exp_rd); end
        checks++; if (m_rsp_err_o !== exp_err) begin failures++; $display("FAIL rnd_err it=%0d got=%b exp=%b", it, m_rsp_err_o, exp_err); end
      end
      tick();
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    m_rsp_ready_i = 1'b0;
    s_req_ready_i = '0;
    s_rsp_valid_i = '0;
    s_rsp_rdata_i = '0;
    s_rsp_err_i   = '0;
    set_req(1'b0, 32'h0, 1'b0);
    test_reset();
    test_single_read();
    test_illegal();
    test_max_outstanding();
    test_switch_order();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
